axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
- Shares the CPU's single AXI read channel (AR/R) between two requesters: instruction fetch (IF) and data load (MEM).
- Sequences one transaction at a time, returns the read data to the requester that issued it, and raises that requester's stall request while it waits.
- stallreq_data drives the highest-priority (full-pipeline) stall input of the stall control unit; stallreq_if drives its fetch stall input.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- INST_ID, 4'h0, ARID used for instruction fetches
- DATA_ID, 4'h1, ARID used for data loads

Ports:
- cpu_clk_50M  in  1  clock
- cpu_rst_n  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request; held with inst_addr until inst_valid
- inst_addr  in  ADDR_W  fetch address
- inst_flush  in  1  discard result of pending/in-flight fetch
- inst_rdata  out  DATA_W  fetched word
- inst_valid  out  1  one-cycle pulse, inst_rdata valid
- stallreq_if  out  1  fetch stall request
- data_req  in  1  load request; held with data_addr/data_size until data_valid
- data_addr  in  ADDR_W  load address
- data_size  in  3  AXI size code (0=byte, 1=half, 2=word)
- data_rdata  out  DATA_W  loaded word
- data_valid  out  1  one-cycle pulse, data_rdata valid
- stallreq_data  out  1  load stall request
- rd_err  out  1  one-cycle pulse with a valid when the response is bad
- arid  out  4
- araddr  out  ADDR_W
- arlen  out  8  constant 0
- arsize  out  3
- arburst  out  2  constant 2'b01
- arvalid  out  1
- arready  in  1
- rid  in  4
- rdata  in  DATA_W
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1

Behaviour:
- Reset (async, cpu_rst_n=0):
  - State is IDLE.
  - arvalid, rready, inst_valid, data_valid and rd_err are 0.
  - arid, araddr, arsize, inst_rdata and data_rdata are 0.
  - owner is DATA and discard is 0.
- The FSM has four states: IDLE, ADDR, RESP, DONE.
- IDLE:
  - If data_req=1: latch data_addr, data_size, owner=DATA, arid=DATA_ID.
  - Else if inst_req=1 and inst_flush=0: latch inst_addr, arsize=3'b010, owner=INST, arid=INST_ID.
  - In either case, go to ADDR. Otherwise stay in IDLE.
  - Data has fixed priority over fetch.
- ADDR:
  - arvalid=1; arid, araddr and arsize are held stable from registers.
  - On arvalid&arready: arvalid drops next cycle and the FSM goes to RESP.
  - arvalid is never withdrawn before arready, including under inst_flush.
- RESP:
  - rready=1.
  - On rvalid&rready&rlast: capture rdata into owner's rdata register and go to DONE.
  - Set the error flag if rresp!=2'b00 or rid!=arid.
  - Beats with rlast=0 are accepted and ignored.
- DONE:
  - The owner's valid pulses for exactly one cycle; rd_err=error flag.
  - Suppressed if owner=INST and discard=1, in which case inst_valid=0 and rd_err=0.
  - Then go to IDLE, clearing discard and the error flag.
  - No arbitration in DONE, so the requester can drop or change its request on the cycle it sees valid.
- discard is set when inst_flush=1 while owner=INST and state is ADDR, RESP or DONE.
- rdata registers hold their value until the next capture for the same owner.
- Stall requests (combinational):
  - stallreq_data = data_req & ~data_valid.
  - stallreq_if = inst_req & ~inst_valid & ~inst_flush.
- Minimum latency, request to valid: 3 cycles (IDLE sample, ADDR with arready=1, RESP with rvalid=1, valid in DONE).
- Simultaneous requests: data is served first; fetch is served in the IDLE after data's DONE.
- Only one transaction is outstanding at a time; arvalid and rready are never both 1.
- Reset mid-transaction aborts immediately to IDLE; the AXI slave is reset by the same SoC reset.

Test Plan:
- Single fetch:
  - Stimulus: inst_req=1, inst_addr=32'hBFC0_0000; arready=1 immediately; rvalid=1, rdata=32'h2408_0001, rlast=1 one cycle later.
  - Required: arid=0, arsize=2, arlen=0, arburst=1; inst_valid pulses 1 cycle with inst_rdata=32'h2408_0001.
  - Required: stallreq_if=1 from request until the valid cycle, 0 in the valid cycle.
- Contention:
  - Stimulus: inst_req and data_req asserted in the same cycle, data_addr=32'h8000_0010, data_size=0.
  - Required: first AR has arid=1, araddr=32'h8000_0010, arsize=0; data_valid precedes the fetch AR; fetch then completes normally.
- Backpressure:
  - Stimulus: arready held 0 for 5 cycles, then rvalid delayed 4 cycles.
  - Required: arvalid stays 1 with araddr stable throughout; rready=1 only in RESP; valid arrives 9 cycles later than the minimum.
- Flush in flight:
  - Stimulus: inst_flush=1 for one cycle during RESP of a fetch.
  - Required: R beat consumed; inst_valid stays 0; FSM returns to IDLE; next fetch proceeds normally.
- Error response:
  - Stimulus: rresp=2'b10 on a data load.
  - Required: data_valid=1 and rd_err=1 in the same cycle; next transaction has rd_err=0.
- Async reset:
  - Stimulus: cpu_rst_n=0 mid-ADDR, between clock edges.
  - Required: arvalid=0 and rready=0 immediately without waiting for a clock edge; after release, state is IDLE and the first request starts cleanly.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-requester (fetch/load) arbiter for a single AXI read channel
module axi_rd_arbiter #(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [3:0] INST_ID = 4'h0,
  parameter logic [3:0] DATA_ID = 4'h1
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_flush,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_valid,
  output logic              stallreq_if,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [2:0]        data_size,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              stallreq_data,
  output logic              rd_err,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic [1:0]        state;
  logic              owner;
  logic              discard;
  logic              err;
  logic [3:0]        arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]        arsize_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              done_ok;

  // Transaction sequencer: arbitrate in IDLE, issue AR, collect last R beat, report in DONE
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state        <= S_IDLE;
      owner        <= OWN_DATA;
      discard      <= 1'b0;
      err          <= 1'b0;
      arid_q       <= 4'h0;
      araddr_q     <= '0;
      arsize_q     <= 3'b000;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_req) begin
            araddr_q <= data_addr;
            arsize_q <= data_size;
            arid_q   <= DATA_ID;
            owner    <= OWN_DATA;
            state    <= S_ADDR;
          end else if (inst_req && !inst_flush) begin
            araddr_q <= inst_addr;
            arsize_q <= 3'b010;
            arid_q   <= INST_ID;
            owner    <= OWN_INST;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          // arvalid is held until the slave accepts, even if the fetch is flushed
          if (inst_flush && owner == OWN_INST) discard <= 1'b1;
          if (arready) state <= S_RESP;
        end
        S_RESP: begin
          if (inst_flush && owner == OWN_INST) discard <= 1'b1;
          // Non-last beats are drained without capture
          if (rvalid && rlast) begin
            if (owner == OWN_DATA) data_rdata_q <= rdata;
            else                   inst_rdata_q <= rdata;
            err   <= (rresp != 2'b00) || (rid != arid_q);
            state <= S_DONE;
          end
        end
        default: begin
          // No arbitration here so requesters may change requests on their valid cycle
          discard <= 1'b0;
          err     <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Completion is reported unless it belongs to a flushed fetch
  assign done_ok = (state == S_DONE) && !(owner == OWN_INST && discard);

  assign inst_valid    = done_ok && (owner == OWN_INST);
  assign data_valid    = done_ok && (owner == OWN_DATA);
  assign rd_err        = done_ok && err;
  assign inst_rdata    = inst_rdata_q;
  assign data_rdata    = data_rdata_q;

  assign stallreq_data = data_req & ~data_valid;
  assign stallreq_if   = inst_req & ~inst_valid & ~inst_flush;

  assign arvalid = (state == S_ADDR);
  assign rready  = (state == S_RESP);
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;

endmodule
